// File: rtl/ex_mem_stage_pkg.sv
// Shared encodings for the EX/MEM stage: FUNCT3 access/branch codes and the
// pipeline-register layout, including the bubble control word.
package ex_mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] pc_br;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } exmem_t;

endpackage

// File: rtl/ex_mem_stage_data_mem.sv
// Byte-enable data memory: one 8-bit array per byte lane, synchronous write,
// combinational read. Contents are not reset.
module ex_mem_stage_data_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [WORDS];

    always_ff @(posedge clk)
      if (be[b]) mem[idx] <= wdata[8*b +: 8];

    assign rdata[8*b +: 8] = mem[idx];
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus MEM stage: branch resolution, sized
// load/store against the data memory, and misalignment detection.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DMEM_WORDS = 1024,
  parameter int DMEM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_mem,
  input  logic        flush_mem,
  input  logic [31:0] ALU_OUT_EX,
  input  logic        ZERO_EX,
  input  logic [31:0] PC_Branch_EX,
  input  logic [31:0] REG_DATA2_EX_FINAL,
  input  logic [4:0]  RD_EX,
  input  logic [2:0]  FUNCT3_EX,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  input  logic        Branch_EX,
  output logic [31:0] ALU_DATA_MEM,
  output logic [31:0] READ_DATA_MEM,
  output logic [4:0]  RD_MEM,
  output logic        RegWrite_MEM,
  output logic        MemtoReg_MEM,
  output logic        PCSrc,
  output logic [31:0] PC_Branch_MEM,
  output logic        MISALIGN_MEM
);

  exmem_t r, r_nxt;

  assign r_nxt = '{
    ctrl:  '{reg_write: RegWrite_EX, mem_to_reg: MemtoReg_EX,
             mem_read: MemRead_EX, mem_write: MemWrite_EX, branch: Branch_EX},
    alu:   ALU_OUT_EX,
    zero:  ZERO_EX,
    pc_br: PC_Branch_EX,
    sdata: REG_DATA2_EX_FINAL,
    rd:    RD_EX,
    f3:    FUNCT3_EX
  };

  // Flush beats stall: a bubble must replace a held instruction.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)          r <= '0;
    else if (flush_mem)  r <= '{ctrl: CTRL_BUBBLE, default: '0};
    else if (!stall_mem) r <= r_nxt;

  logic [31:0]        addr;
  logic [DMEM_AW-1:0] idx;
  logic               half_acc, word_acc, misalign;
  logic [3:0]         be;
  logic [31:0]        wdata, rdata, rshift;

  assign addr     = r.alu;
  assign idx      = addr[DMEM_AW+1:2];
  assign half_acc = (r.f3 == F3_LH) || (r.f3 == F3_LHU);
  assign word_acc = (r.f3 == F3_LW);
  assign misalign = (r.ctrl.mem_read | r.ctrl.mem_write) &
                    ((half_acc & addr[0]) | (word_acc & (addr[1:0] != 2'b00)));

  // rst_n gates the enable so an edge seen while in reset never writes.
  always_comb begin
    be    = 4'b0000;
    wdata = r.sdata;
    if (r.ctrl.mem_write && !stall_mem && !misalign && rst_n) begin
      case (r.f3)
        F3_SB: begin
          be    = 4'b0001 << addr[1:0];
          wdata = {4{r.sdata[7:0]}};
        end
        F3_SH: begin
          be    = addr[1] ? 4'b1100 : 4'b0011;
          wdata = {2{r.sdata[15:0]}};
        end
        F3_SW:   be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  ex_mem_stage_data_mem #(.WORDS(DMEM_WORDS), .AW(DMEM_AW)) u_dmem (
    .clk   (clk),
    .idx   (idx),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign rshift = rdata >> {addr[1:0], 3'b000};

  always_comb begin
    READ_DATA_MEM = '0;
    if (r.ctrl.mem_read && !misalign) begin
      case (r.f3)
        F3_LB:   READ_DATA_MEM = {{24{rshift[7]}}, rshift[7:0]};
        F3_LH:   READ_DATA_MEM = {{16{rshift[15]}}, rshift[15:0]};
        F3_LW:   READ_DATA_MEM = rdata;
        F3_LBU:  READ_DATA_MEM = {24'h0, rshift[7:0]};
        F3_LHU:  READ_DATA_MEM = {16'h0, rshift[15:0]};
        default: READ_DATA_MEM = '0;
      endcase
    end
  end

  assign PCSrc = r.ctrl.branch & (((r.f3 == F3_BEQ) &  r.zero) |
                                  ((r.f3 == F3_BNE) & ~r.zero));

  assign ALU_DATA_MEM  = r.alu;
  assign RD_MEM        = r.rd;
  assign RegWrite_MEM  = r.ctrl.reg_write;
  assign MemtoReg_MEM  = r.ctrl.mem_to_reg;
  assign PC_Branch_MEM = r.pc_br;
  assign MISALIGN_MEM  = misalign;

  // Address bits above the word index are intentionally ignored (wraparound).
  logic unused_addr;
  assign unused_addr = ^addr[31:DMEM_AW+2];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: stimulus pushes expected MEM-stage values
// tagged with the cycle they must appear; a negedge monitor pops and compares.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_mem, flush_mem;
  logic [31:0] ALU_OUT_EX, PC_Branch_EX, REG_DATA2_EX_FINAL;
  logic        ZERO_EX;
  logic [4:0]  RD_EX;
  logic [2:0]  FUNCT3_EX;
  logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX;
  logic [31:0] ALU_DATA_MEM, READ_DATA_MEM, PC_Branch_MEM;
  logic [4:0]  RD_MEM;
  logic        RegWrite_MEM, MemtoReg_MEM, PCSrc, MISALIGN_MEM;

  ex_mem_stage #(.DMEM_WORDS(1024), .DMEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .stall_mem(stall_mem), .flush_mem(flush_mem),
    .ALU_OUT_EX(ALU_OUT_EX), .ZERO_EX(ZERO_EX), .PC_Branch_EX(PC_Branch_EX),
    .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL), .RD_EX(RD_EX), .FUNCT3_EX(FUNCT3_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX),
    .ALU_DATA_MEM(ALU_DATA_MEM), .READ_DATA_MEM(READ_DATA_MEM), .RD_MEM(RD_MEM),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .PCSrc(PCSrc),
    .PC_Branch_MEM(PC_Branch_MEM), .MISALIGN_MEM(MISALIGN_MEM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic        bub;   // bubble: data fields are don't-care
    logic [31:0] alu, rdata, pcbr;
    logic [4:0]  rd;
    logic        rw, m2r, pcsrc, mis;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic [31:0] alu, input logic z, input logic [31:0] pcb,
                     input logic [31:0] sd, input logic [4:0] rd, input logic [2:0] f3,
                     input logic rw, input logic m2r, input logic mr, input logic mw,
                     input logic br);
    ALU_OUT_EX = alu; ZERO_EX = z; PC_Branch_EX = pcb; REG_DATA2_EX_FINAL = sd;
    RD_EX = rd; FUNCT3_EX = f3; RegWrite_EX = rw; MemtoReg_EX = m2r;
    MemRead_EX = mr; MemWrite_EX = mw; Branch_EX = br;
  endtask

  task automatic expect_at(input int c, input string nm, input logic bub,
                           input logic [31:0] alu, input logic [4:0] rd,
                           input logic rw, input logic m2r, input logic [31:0] rdata,
                           input logic pcsrc, input logic [31:0] pcbr, input logic mis);
    exp_t x;
    x.cyc = c; x.name = nm; x.bub = bub; x.alu = alu; x.rd = rd; x.rw = rw;
    x.m2r = m2r; x.rdata = rdata; x.pcsrc = pcsrc; x.pcbr = pcbr; x.mis = mis;
    q.push_back(x);
  endtask

  task automatic store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic mis);
    drv(a, 1'b0, 32'h0, d, 5'd0, f3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_at(cyc + 1, nm, 1'b0, a, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, mis);
    step();
  endtask

  task automatic load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                      input logic [4:0] rd, input logic [31:0] rdata, input logic mis);
    drv(a, 1'b0, 32'h0, 32'h0, rd, f3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_at(cyc + 1, nm, 1'b0, a, rd, 1'b1, 1'b1, rdata, 1'b0, 32'h0, mis);
    step();
  endtask

  task automatic branch(input string nm, input logic [2:0] f3, input logic z,
                        input logic pcsrc, input logic fl, input logic st);
    flush_mem = fl; stall_mem = st;
    drv(32'h0, z, 32'h40, 32'h0, 5'd0, f3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(cyc + 1, nm, fl, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, pcsrc, 32'h40, 1'b0);
    step();
    flush_mem = 1'b0; stall_mem = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (!(RegWrite_MEM === e.rw && MemtoReg_MEM === e.m2r && PCSrc === e.pcsrc &&
                     MISALIGN_MEM === e.mis && READ_DATA_MEM === e.rdata &&
                     (e.bub || (ALU_DATA_MEM === e.alu && RD_MEM === e.rd &&
                                PC_Branch_MEM === e.pcbr)))) begin
        errors++;
        $display("FAIL %s: got alu=%h rd=%0d rw=%b m2r=%b rdata=%h pcsrc=%b pcbr=%h mis=%b | want alu=%h rd=%0d rw=%b m2r=%b rdata=%h pcsrc=%b pcbr=%h mis=%b bub=%b",
                 e.name, ALU_DATA_MEM, RD_MEM, RegWrite_MEM, MemtoReg_MEM, READ_DATA_MEM,
                 PCSrc, PC_Branch_MEM, MISALIGN_MEM, e.alu, e.rd, e.rw, e.m2r, e.rdata,
                 e.pcsrc, e.pcbr, e.mis, e.bub);
      end
    end
  end

  initial begin
    // Reset with random inputs: register must stay cleared.
    rst_n = 1'b0;
    stall_mem = 1'($urandom); flush_mem = 1'($urandom);
    drv($urandom, 1'($urandom), $urandom, $urandom, 5'($urandom), 3'($urandom),
        1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); step();
    expect_at(cyc, "reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    stall_mem = 1'b0; flush_mem = 1'b0;
    drv(32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    step();

    store("sw_10",   F3_SW(), 32'h10, 32'hDEADBEEF, 1'b0);
    load ("lw_10",   F3_LW(), 32'h10, 5'd5, 32'hDEADBEEF, 1'b0);
    store("sb_13",   3'b000, 32'h13, 32'h00000080, 1'b0);
    load ("lb_13",   3'b000, 32'h13, 5'd6, 32'hFFFFFF80, 1'b0);
    load ("lbu_13",  3'b100, 32'h13, 5'd7, 32'h00000080, 1'b0);
    load ("lw_10b",  3'b010, 32'h10, 5'd8, 32'h80ADBEEF, 1'b0);
    store("sh_11_mis", 3'b001, 32'h11, 32'h00001234, 1'b1);
    load ("lw_10c",  3'b010, 32'h10, 5'd9, 32'h80ADBEEF, 1'b0);
    load ("lw_12_mis", 3'b010, 32'h12, 5'd10, 32'h0, 1'b1);
    load ("lh_12",   3'b001, 32'h12, 5'd11, 32'hFFFF80AD, 1'b0);
    load ("lhu_12",  3'b101, 32'h12, 5'd12, 32'h000080AD, 1'b0);
    store("sh_10",   3'b001, 32'h10, 32'h5555AAAA, 1'b0);
    load ("lw_10d",  3'b010, 32'h10, 5'd13, 32'h80ADAAAA, 1'b0);
    load ("lw_wrap", 3'b010, 32'h1010, 5'd14, 32'h80ADAAAA, 1'b0);

    branch("beq_t",   3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    branch("bne_nt",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    branch("bne_t",   3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    branch("blt_nt",  3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
    branch("beq_flush", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

    // SW held in MEM by a 2-cycle stall, then a load of the same word.
    store("sw_20", 3'b010, 32'h20, 32'h11112222, 1'b0);
    stall_mem = 1'b1;
    drv(32'h20, 1'b0, 32'h0, 32'h0, 5'd7, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_at(cyc + 1, "stall_hold1", 1'b0, 32'h20, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    expect_at(cyc + 1, "stall_hold2", 1'b0, 32'h20, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    stall_mem = 1'b0;
    expect_at(cyc + 1, "lw_20", 1'b0, 32'h20, 5'd7, 1'b1, 1'b1, 32'h11112222, 1'b0, 32'h0, 1'b0);
    step();
    branch("flush_stall", 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset asserted while a store sits in MEM: that store must not commit.
    store("sw_24a", 3'b010, 32'h24, 32'hCAFEF00D, 1'b0);
    drv(32'h24, 1'b0, 32'h0, 32'h0BADBEEF, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drv(32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    expect_at(cyc, "rst_mid", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    step();
    load("lw_24", 3'b010, 32'h24, 5'd3, 32'hCAFEF00D, 1'b0);

    drv(32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [2:0] F3_SW();
    return 3'b010;
  endfunction
  function automatic logic [2:0] F3_LW();
    return 3'b010;
  endfunction

endmodule
